// File: rtl/ff_bank_pkg.sv
// Shared types and the per-bit next-state function for the multi-mode flop bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_t;

  // Returns {nxt, illegal}; illegal flags S=R=1 in SR mode, where the bit holds.
  function automatic logic [1:0] next_bit(mode_t mode, logic q, logic a, logic b);
    logic nxt;
    logic illegal;
    nxt     = q;
    illegal = 1'b0;
    case (mode)
      MODE_D: nxt = a;
      MODE_T: nxt = q ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_SR: begin
        case ({a, b})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11:   illegal = 1'b1;
          default: nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return {nxt, illegal};
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One bit of the multi-mode flop bank; exposes its next value so the top can
// derive the change pulse and toggle count without recomputing the mode decode.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       q_o,
  output logic       nxt_o,
  output logic       illegal_o
);

  logic       q_q;
  logic       q_d;
  logic       illegal;
  logic [1:0] upd;

  always_comb begin
    upd     = next_bit(mode_t'(mode_i), q_q, a_i, b_i);
    q_d     = q_q;
    illegal = 1'b0;
    // clr overrides the update and suppresses the illegal-SR flag.
    if (clr_i) begin
      q_d = RESET_BIT;
    end else if (en_i) begin
      q_d     = upd[1];
      illegal = upd[0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= RESET_BIT;
    else       q_q <= q_d;
  end

  assign q_o       = q_q;
  assign nxt_o     = q_d;
  assign illegal_o = illegal;

endmodule

// File: rtl/ff_bank_multimode.sv
// WIDTH-bit bank of D/T/JK/SR flops under one run-time mode, with change pulse
// and sticky illegal-SR flag. Define FF_BANK_TCOUNT_EN to add the toggle_cnt_o counter.
module ff_bank_multimode
  import ff_bank_pkg::*;
#(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             err_clr_i,
`ifdef FF_BANK_TCOUNT_EN
  output logic [CNT_W-1:0] toggle_cnt_o,
`endif
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o,
  output logic             changed_o,
  output logic             sr_err_o
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] illegal;

  logic changed_q, changed_d;
  logic sr_err_q,  sr_err_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr_i),
      .en_i      (en_i),
      .mode_i    (mode_i),
      .a_i       (a_i[i]),
      .b_i       (b_i[i]),
      .q_o       (q[i]),
      .nxt_o     (q_nxt[i]),
      .illegal_o (illegal[i])
    );
  end

  // A new illegal SR wins over err_clr in the same cycle.
  always_comb begin
    changed_d = (q_nxt != q);
    sr_err_d  = (|illegal) | (sr_err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      changed_q <= 1'b0;
      sr_err_q  <= 1'b0;
    end else begin
      changed_q <= changed_d;
      sr_err_q  <= sr_err_d;
    end
  end

`ifdef FF_BANK_TCOUNT_EN
  localparam int unsigned PW    = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] flips;

  // Saturating accumulate of flipped bits; clr flips count too, only rst zeroes it.
  always_comb begin
    flips = q_nxt ^ q;
    pop   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + SUM_W'(flips[i]);
    end
    sum   = SUM_W'(cnt_q) + pop;
    cnt_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign toggle_cnt_o = cnt_q;
`endif

  assign q_o       = q;
  assign qn_o      = ~q;
  assign changed_o = changed_q;
  assign sr_err_o  = sr_err_q;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Directed bench for ff_bank_multimode (WIDTH=8, RESET_VAL=0); toggle counter
// checks, including a CNT_W=3 saturation instance, are built with FF_BANK_TCOUNT_EN.
module tb_ff_bank_multimode;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         en  = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] q, qn;
  logic         changed, sr_err;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef FF_BANK_TCOUNT_EN
  logic [15:0]  tcnt;
  logic [2:0]   tcnt3;
  logic [W-1:0] q3, qn3;
  logic         changed3, sr_err3;
`endif

  ff_bank_multimode #(.WIDTH(W), .RESET_VAL(8'h00), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (clr),
    .en_i         (en),
    .mode_i       (mode),
    .a_i          (a),
    .b_i          (b),
    .err_clr_i    (err_clr),
`ifdef FF_BANK_TCOUNT_EN
    .toggle_cnt_o (tcnt),
`endif
    .q_o          (q),
    .qn_o         (qn),
    .changed_o    (changed),
    .sr_err_o     (sr_err)
  );

`ifdef FF_BANK_TCOUNT_EN
  ff_bank_multimode #(.WIDTH(W), .RESET_VAL(8'h00), .CNT_W(3)) dut3 (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (clr),
    .en_i         (en),
    .mode_i       (mode),
    .a_i          (a),
    .b_i          (b),
    .err_clr_i    (err_clr),
    .toggle_cnt_o (tcnt3),
    .q_o          (q3),
    .qn_o         (qn3),
    .changed_o    (changed3),
    .sr_err_o     (sr_err3)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs at negedge, then sample 1 ns after the posedge.
  task automatic apply(input logic c, input logic e, input logic [1:0] m,
                       input logic [W-1:0] av, input logic [W-1:0] bv, input logic ec);
    @(negedge clk);
    clr = c; en = e; mode = m; a = av; b = bv; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_vec++; if (q !== 8'h00 || qn !== 8'hFF) begin n_miss++; $display("FAIL reset_q q=%h qn=%h exp 00/FF", q, qn); end
    n_vec++; if (changed !== 1'b0 || sr_err !== 1'b0) begin n_miss++; $display("FAIL reset_flags changed=%b sr_err=%b exp 0/0", changed, sr_err); end
    @(negedge clk); rst = 1'b0;
    apply(1'b0, 1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
    n_vec++; if (sr_err !== 1'b1 || q !== 8'h00) begin n_miss++; $display("FAIL pre_rst_srerr sr_err=%b q=%h exp 1/00", sr_err, q); end
    apply(1'b0, 1'b1, 2'b00, 8'h5A, 8'h00, 1'b0);
    n_vec++; if (q !== 8'h5A || changed !== 1'b1) begin n_miss++; $display("FAIL pre_rst_load q=%h changed=%b exp 5A/1", q, changed); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (q !== 8'h00 || qn !== 8'hFF) begin n_miss++; $display("FAIL async_rst_q q=%h qn=%h exp 00/FF", q, qn); end
    n_vec++; if (changed !== 1'b0 || sr_err !== 1'b0) begin n_miss++; $display("FAIL async_rst_flags changed=%b sr_err=%b exp 0/0", changed, sr_err); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_d;
    apply(1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 1'b0);
    n_vec++; if (q !== 8'hA5 || changed !== 1'b1) begin n_miss++; $display("FAIL d_load q=%h changed=%b exp A5/1", q, changed); end
    n_vec++; if (qn !== 8'h5A) begin n_miss++; $display("FAIL d_qn qn=%h exp 5A", qn); end
    apply(1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 1'b0);
    n_vec++; if (q !== 8'hA5 || changed !== 1'b0) begin n_miss++; $display("FAIL d_same q=%h changed=%b exp A5/0", q, changed); end
  endtask

  task automatic test_t;
    apply(1'b0, 1'b1, 2'b01, 8'h0F, 8'hFF, 1'b0);
    n_vec++; if (q !== 8'hAA || changed !== 1'b1) begin n_miss++; $display("FAIL t_toggle q=%h changed=%b exp AA/1", q, changed); end
    apply(1'b0, 1'b0, 2'b01, 8'hFF, 8'h00, 1'b0);
    n_vec++; if (q !== 8'hAA || changed !== 1'b0) begin n_miss++; $display("FAIL t_hold_en0 q=%h changed=%b exp AA/0", q, changed); end
  endtask

  // AA with J=F0 K=3C: set 7-6, toggle 5-4, clear 3-2, hold 1-0 -> D2.
  task automatic test_jk;
    apply(1'b0, 1'b1, 2'b10, 8'hF0, 8'h3C, 1'b0);
    n_vec++; if (q !== 8'hD2 || changed !== 1'b1) begin n_miss++; $display("FAIL jk_mix q=%h changed=%b exp D2/1", q, changed); end
  endtask

  // D2 with S=01 R=81: bit0 illegal (holds 0), bit7 cleared -> 52.
  task automatic test_sr;
    apply(1'b0, 1'b1, 2'b11, 8'h01, 8'h81, 1'b0);
    n_vec++; if (q !== 8'h52 || sr_err !== 1'b1 || changed !== 1'b1) begin n_miss++; $display("FAIL sr_illegal q=%h sr_err=%b changed=%b exp 52/1/1", q, sr_err, changed); end
    apply(1'b0, 1'b0, 2'b11, 8'h00, 8'h00, 1'b1);
    n_vec++; if (sr_err !== 1'b0) begin n_miss++; $display("FAIL sr_err_clr sr_err=%b exp 0", sr_err); end
    apply(1'b0, 1'b1, 2'b11, 8'h01, 8'h01, 1'b1);
    n_vec++; if (sr_err !== 1'b1 || q !== 8'h52 || changed !== 1'b0) begin n_miss++; $display("FAIL sr_set_wins sr_err=%b q=%h changed=%b exp 1/52/0", sr_err, q, changed); end
  endtask

  task automatic test_clr;
    apply(1'b1, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0);
    n_vec++; if (q !== 8'h00 || changed !== 1'b1 || sr_err !== 1'b1) begin n_miss++; $display("FAIL clr_over_t q=%h changed=%b sr_err=%b exp 00/1/1", q, changed, sr_err); end
`ifdef FF_BANK_TCOUNT_EN
    n_vec++; if (tcnt !== 16'd16) begin n_miss++; $display("FAIL tcnt_after_clr got %0d exp 16", tcnt); end
`endif
    apply(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    apply(1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0);
    n_vec++; if (q !== 8'h00 || changed !== 1'b0 || sr_err !== 1'b0) begin n_miss++; $display("FAIL clr_at_reset_val q=%h changed=%b sr_err=%b exp 00/0/0", q, changed, sr_err); end
  endtask

  task automatic test_back_to_back;
    apply(1'b0, 1'b1, 2'b00, 8'h0F, 8'h00, 1'b0);
    n_vec++; if (q !== 8'h0F || changed !== 1'b1) begin n_miss++; $display("FAIL b2b_d q=%h changed=%b exp 0F/1", q, changed); end
    apply(1'b0, 1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0);
    n_vec++; if (q !== 8'hF0 || qn !== 8'h0F) begin n_miss++; $display("FAIL b2b_jk_toggle q=%h qn=%h exp F0/0F", q, qn); end
    apply(1'b0, 1'b1, 2'b11, 8'h03, 8'h00, 1'b0);
    n_vec++; if (q !== 8'hF3 || sr_err !== 1'b0 || changed !== 1'b1) begin n_miss++; $display("FAIL b2b_sr_set q=%h sr_err=%b changed=%b exp F3/0/1", q, sr_err, changed); end
    apply(1'b0, 1'b1, 2'b01, 8'h00, 8'hFF, 1'b0);
    n_vec++; if (q !== 8'hF3 || changed !== 1'b0) begin n_miss++; $display("FAIL b2b_t_zero q=%h changed=%b exp F3/0", q, changed); end
`ifdef FF_BANK_TCOUNT_EN
    n_vec++; if (tcnt !== 16'd30) begin n_miss++; $display("FAIL tcnt_total got %0d exp 30", tcnt); end
    n_vec++; if (tcnt3 !== 3'd7) begin n_miss++; $display("FAIL tcnt3_sat got %0d exp 7", tcnt3); end
`endif
  endtask

  initial begin
    test_reset();
    test_d();
    test_t();
    test_jk();
    test_sr();
    test_clr();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
